// File: rtl/vga_overlay_pkg.sv
// rtl/vga_overlay_pkg.sv - VGA 640x480 timing constants, target box geometry/colours and round FSM types
package vga_overlay_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int HS_START  = H_VISIBLE + H_FRONT;
    localparam int HS_END    = HS_START + H_SYNC;
    localparam int VS_START  = V_VISIBLE + V_FRONT;
    localparam int VS_END    = VS_START + V_SYNC;

    localparam int BOX_SIZE  = 20;
    localparam int LEFT_X    = 170;
    localparam int RIGHT_X   = 450;
    localparam int TOP_Y     = 125;
    localparam int BOTTOM_Y  = 335;

    localparam logic [11:0] COL_LT    = 12'h00F;
    localparam logic [11:0] COL_RT    = 12'hF00;
    localparam logic [11:0] COL_LB    = 12'h888;
    localparam logic [11:0] COL_RB    = 12'h0F0;
    localparam logic [11:0] COL_DONE  = 12'hFFF;
    localparam logic [11:0] COL_FLASH = 12'hFFF;
    localparam logic [11:0] COL_CROSS = 12'hFF0;

    typedef enum logic {S_PLAY, S_CLEAR} round_state_t;
    typedef enum logic [1:0] {BOX_LT, BOX_RT, BOX_LB, BOX_RB} box_idx_t;

    // Bit 0 of the box index selects the right column, bit 1 the bottom row.
    function automatic int box_x(input box_idx_t i);
        return i[0] ? RIGHT_X : LEFT_X;
    endfunction

    function automatic int box_y(input box_idx_t i);
        return i[1] ? BOTTOM_Y : TOP_Y;
    endfunction

    function automatic logic [11:0] box_colour(input box_idx_t i);
        case (i)
            BOX_LT:  return COL_LT;
            BOX_RT:  return COL_RT;
            BOX_LB:  return COL_LB;
            default: return COL_RB;
        endcase
    endfunction

    // Half-open square test: x0 <= x < x0+size, y0 <= y < y0+size.
    function automatic logic in_square(input int x, input int y, input int x0, input int y0, input int size);
        return (x >= x0) && (x < x0 + size) && (y >= y0) && (y < y0 + size);
    endfunction

endpackage

// File: rtl/vga_target_overlay_if.sv
// rtl/vga_target_overlay_if.sv - camera/detector/monitor signal bundle of the target overlay
interface vga_target_overlay_if;
    logic [3:0] r_in;
    logic [3:0] g_in;
    logic [3:0] b_in;
    logic       pass_LT;
    logic       pass_RT;
    logic       pass_LB;
    logic       pass_RB;
    logic [9:0] x_pixel;
    logic [9:0] y_pixel;
    logic       DE;
    logic       vsync;
    logic       vga_hsync;
    logic       vga_vsync;
    logic       vga_de;
    logic [3:0] r_out;
    logic [3:0] g_out;
    logic [3:0] b_out;
    logic [3:0] done_mask;
    logic       round_clear;

    modport master (
        input  r_in, g_in, b_in, pass_LT, pass_RT, pass_LB, pass_RB,
        output x_pixel, y_pixel, DE, vsync, vga_hsync, vga_vsync, vga_de,
        output r_out, g_out, b_out, done_mask, round_clear
    );

    modport slave (
        output r_in, g_in, b_in, pass_LT, pass_RT, pass_LB, pass_RB,
        input  x_pixel, y_pixel, DE, vsync, vga_hsync, vga_vsync, vga_de,
        input  r_out, g_out, b_out, done_mask, round_clear
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 800x525 raster counters with registered DE/syncs and frame_end strobe
module vga_timing_gen
    import vga_overlay_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       de,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_end
);

    logic       h_wrap;
    logic [9:0] h_next;
    logic [9:0] v_next;

    // Next raster position; DE/syncs are decoded from it so they line up with the registered counters.
    always_comb begin
        h_wrap = (h_cnt == 10'(H_TOTAL - 1));
        h_next = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_next = v_cnt;
        if (h_wrap) begin
            v_next = (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
        end
    end

    // Counter and timing-strobe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
            de    <= 1'b0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            h_cnt <= h_next;
            v_cnt <= v_next;
            de    <= (h_next < 10'(H_VISIBLE)) && (v_next < 10'(V_VISIBLE));
            hsync <= !((h_next >= 10'(HS_START)) && (h_next < 10'(HS_END)));
            vsync <= !((v_next >= 10'(VS_START)) && (v_next < 10'(VS_END)));
        end
    end

    assign frame_end = (h_cnt == 10'd0) && (v_cnt == 10'(V_VISIBLE));

endmodule

// File: rtl/vga_target_overlay.sv
// rtl/vga_target_overlay.sv - target-box overlay, frame scoring and round FSM; OVERLAY_CROSSHAIR_EN adds a centre crosshair
module vga_target_overlay
    import vga_overlay_pkg::*;
#(
    parameter int HOLD_FRAMES  = 8,
    parameter int FLASH_FRAMES = 30,
    parameter int BORDER       = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    vga_target_overlay_if.master bus
);

    logic [9:0]      h;
    logic [9:0]      v;
    logic            de0;
    logic            hs0;
    logic            vs0;
    logic            frame_end;

    round_state_t    state;
    round_state_t    state_n;
    logic [3:0][7:0] hold_cnt;
    logic [3:0][7:0] hold_n;
    logic [7:0]      flash_cnt;
    logic [7:0]      flash_n;
    logic [3:0]      done_mask;
    logic [3:0]      done_n;
    logic [3:0]      pass;

    int              hx;
    int              vy;
    logic            ring_hit;
    box_idx_t        ring_idx;
    logic [11:0]     pix;
    logic            round_clear_d;

    logic            hsync_q;
    logic            vsync_q;
    logic            de_q;
    logic [11:0]     rgb_q;
    logic            round_clear_q;

    vga_timing_gen u_timing (
        .clk       (clk),
        .reset_n   (reset_n),
        .h_cnt     (h),
        .v_cnt     (v),
        .de        (de0),
        .hsync     (hs0),
        .vsync     (vs0),
        .frame_end (frame_end)
    );

    assign pass = {bus.pass_RB, bus.pass_LB, bus.pass_RT, bus.pass_LT};
    assign hx   = int'(h);
    assign vy   = int'(v);

    // Round state and scoring counters; they only move on frame_end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_PLAY;
            hold_cnt  <= '0;
            flash_cnt <= 8'd0;
            done_mask <= 4'd0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_n;
            flash_cnt <= flash_n;
            done_mask <= done_n;
        end
    end

    // Next-state: per-box consecutive-pass counting in PLAY, flash countdown in CLEAR.
    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        flash_n = flash_cnt;
        done_n  = done_mask;
        if (frame_end) begin
            case (state)
                S_PLAY: begin
                    for (int i = 0; i < 4; i++) begin
                        if (!done_mask[i]) begin
                            if (pass[i]) begin
                                hold_n[i] = hold_cnt[i] + 8'd1;
                                if (hold_n[i] == 8'(HOLD_FRAMES)) begin
                                    done_n[i] = 1'b1;
                                end
                            end else begin
                                hold_n[i] = 8'd0;
                            end
                        end
                    end
                    if (done_n == 4'hF) begin
                        state_n = S_CLEAR;
                        flash_n = 8'd0;
                    end
                end
                default: begin
                    if (flash_cnt == 8'(FLASH_FRAMES - 1)) begin
                        state_n = S_PLAY;
                        done_n  = 4'd0;
                        hold_n  = '0;
                        flash_n = 8'd0;
                    end else begin
                        flash_n = flash_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    // Border ring lookup: BORDER pixels around each box, excluding the box interior.
    always_comb begin
        ring_hit = 1'b0;
        ring_idx = BOX_LT;
        for (int i = 0; i < 4; i++) begin
            if (in_square(hx, vy, box_x(box_idx_t'(i)) - BORDER, box_y(box_idx_t'(i)) - BORDER,
                          BOX_SIZE + 2 * BORDER) &&
                !in_square(hx, vy, box_x(box_idx_t'(i)), box_y(box_idx_t'(i)), BOX_SIZE)) begin
                ring_hit = 1'b1;
                ring_idx = box_idx_t'(i);
            end
        end
    end

`ifdef OVERLAY_CROSSHAIR_EN
    logic cross_hit;
    assign cross_hit = ((hx >= 312) && (hx <= 327) && (vy >= 239) && (vy <= 240)) ||
                       ((vy >= 232) && (vy <= 247) && (hx >= 319) && (hx <= 320));
`endif

    // Output decode: pixel priority chain and the PLAY->CLEAR transition strobe.
    always_comb begin
        round_clear_d = (state == S_PLAY) && (state_n == S_CLEAR);
        pix           = {bus.r_in, bus.g_in, bus.b_in};
        if (!de0) begin
            pix = 12'h000;
        end else if ((state == S_CLEAR) && !flash_cnt[2]) begin
            pix = COL_FLASH;
        end
`ifdef OVERLAY_CROSSHAIR_EN
        else if (cross_hit) begin
            pix = COL_CROSS;
        end
`endif
        else if (ring_hit) begin
            pix = done_mask[ring_idx] ? COL_DONE : box_colour(ring_idx);
        end
    end

    // Stage-1 monitor registers: timing delayed one clock alongside the composited pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            rgb_q         <= 12'h000;
            round_clear_q <= 1'b0;
        end else begin
            hsync_q       <= hs0;
            vsync_q       <= vs0;
            de_q          <= de0;
            rgb_q         <= pix;
            round_clear_q <= round_clear_d;
        end
    end

    assign bus.x_pixel     = h;
    assign bus.y_pixel     = v;
    assign bus.DE          = de0;
    assign bus.vsync       = vs0;
    assign bus.vga_hsync   = hsync_q;
    assign bus.vga_vsync   = vsync_q;
    assign bus.vga_de      = de_q;
    assign bus.r_out       = rgb_q[11:8];
    assign bus.g_out       = rgb_q[7:4];
    assign bus.b_out       = rgb_q[3:0];
    assign bus.done_mask   = done_mask;
    assign bus.round_clear = round_clear_q;

endmodule
